// File: rtl/multi_spi_tx_if.sv
// Handshake and quad-lane SPI bus bundle for multi_spi_tx.
// master = word source and line observer, slave = the serializer itself.
interface multi_spi_tx_if #(
  parameter int REGSIZE = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [REGSIZE-1:0] din;
  logic               sclk;
  logic               cs_n;
  logic [3:0]         dout;
  logic               busy;
  logic               done;

  modport master (
    output in_valid, din,
    input  in_ready, sclk, cs_n, dout, busy, done
  );

  modport slave (
    input  in_valid, din,
    output in_ready, sclk, cs_n, dout, busy, done
  );
endinterface

// File: rtl/multi_spi_tx.sv
// Quad-lane SPI-style serializer: one REGSIZE-bit word per frame, MSB nibble first,
// mode 0 (lanes change on sclk fall, sampled on sclk rise), active-low frame select.
module multi_spi_tx #(
  parameter int REGSIZE = 32,
  parameter int CLKDIV  = 2
) (
  input logic          clk,
  input logic          rst_n,
  multi_spi_tx_if.slave bus
);

  localparam int NIBBLES = REGSIZE / 4;
  localparam int HW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKDIV - 1);
  localparam logic [NW-1:0] NIB_LAST  = NW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CS_HOLD} state_t;

  state_t             state;
  logic [REGSIZE-1:0] shreg;
  logic [HW-1:0]      half_cnt;
  logic [NW-1:0]      nib_cnt;
  logic               sclk_q;
  logic               cs_n_q;
  logic               done_q;
  logic [3:0]         dout_q;
  logic               ready;

  assign ready        = (state == IDLE);
  assign bus.in_ready = ready;
  assign bus.busy     = (state != IDLE);
  assign bus.sclk     = sclk_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.dout     = dout_q;
  assign bus.done     = done_q;

  // shreg holds the nibbles not yet presented; the first one goes straight to dout at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      half_cnt <= '0;
      nib_cnt  <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      done_q   <= 1'b0;
      dout_q   <= 4'h0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && ready) begin
            state    <= SHIFT;
            cs_n_q   <= 1'b0;
            sclk_q   <= 1'b0;
            dout_q   <= bus.din[REGSIZE-1 -: 4];
            shreg    <= bus.din << 4;
            half_cnt <= '0;
            nib_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (nib_cnt == NIB_LAST) begin
              // last falling edge: lanes keep the final nibble through the hold time
              state  <= CS_HOLD;
              sclk_q <= 1'b0;
            end else begin
              sclk_q  <= 1'b0;
              dout_q  <= shreg[REGSIZE-1 -: 4];
              shreg   <= shreg << 4;
              nib_cnt <= nib_cnt + NW'(1);
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        CS_HOLD: begin
          if (half_cnt == HALF_LAST) begin
            state    <= IDLE;
            cs_n_q   <= 1'b1;
            dout_q   <= 4'h0;
            done_q   <= 1'b1;
            half_cnt <= '0;
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_spi_tx.sv
// Directed bench for multi_spi_tx: a 32-bit/CLKDIV=2 instance driven from a vector table
// plus hand-written corner sequences, and an 8-bit/CLKDIV=1 instance.
module tb_multi_spi_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_spi_tx_if #(.REGSIZE(32)) a_if ();
  multi_spi_tx_if #(.REGSIZE(8))  b_if ();

  multi_spi_tx #(.REGSIZE(32), .CLKDIV(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  multi_spi_tx #(.REGSIZE(8),  .CLKDIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp_nibs;
    int          exp_rises;
    int          exp_cs_low;
    bit          inject;
  } vec_t;

  vec_t vecs [3];

  // Line monitor for instance A, sampled on the falling clk edge
  logic [31:0] acc_nibs = '0;
  int          acc_rises = 0;
  int          acc_cs_low = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_done = 1'b0;
  int          ncyc = 0;
  int          last_rise = 0;
  int          period_bad = 0;
  int          done_bad = 0;
  int          done_total = 0;
  int          cs_high_run = 0;
  int          last_gap = 0;
  int          frames_a = 0;
  logic [31:0] nib_hist [$];
  int          rise_hist [$];
  int          cs_hist [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_nibs   = '0;
      acc_rises  = 0;
      acc_cs_low = 0;
      prev_sclk  = 1'b0;
      prev_cs    = 1'b1;
      prev_done  = 1'b0;
    end else begin
      if (a_if.cs_n === 1'b0) acc_cs_low++;
      if (a_if.sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (acc_rises > 0 && (ncyc - last_rise) != 4) period_bad++;
        last_rise = ncyc;
        acc_nibs  = {acc_nibs[27:0], a_if.dout};
        acc_rises++;
      end
      if (a_if.cs_n === 1'b0 && prev_cs === 1'b1) last_gap = cs_high_run;
      cs_high_run = (a_if.cs_n === 1'b1) ? cs_high_run + 1 : 0;
      if (a_if.done === 1'b1) begin
        done_total++;
        if (a_if.cs_n !== 1'b1 || a_if.dout !== 4'h0 || a_if.sclk !== 1'b0 ||
            prev_cs !== 1'b0 || prev_done === 1'b1)
          done_bad++;
        nib_hist.push_back(acc_nibs);
        rise_hist.push_back(acc_rises);
        cs_hist.push_back(acc_cs_low);
        frames_a++;
        acc_nibs   = '0;
        acc_rises  = 0;
        acc_cs_low = 0;
      end
      prev_sclk = a_if.sclk;
      prev_cs   = a_if.cs_n;
      prev_done = a_if.done;
    end
    ncyc++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Present a word on A and return once the handshake edge has passed
  task automatic apply_stimulus(input logic [31:0] word);
    bit got;
    got = 1'b0;
    @(negedge clk);
    a_if.in_valid = 1'b1;
    a_if.din      = word;
    for (int n = 0; n < 200; n++) begin
      if (a_if.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_output("handshake_ready", got, 1'b1);
    @(posedge clk);
    @(negedge clk);
    a_if.in_valid = 1'b0;
    a_if.din      = 32'h5A5A_C3C3;
  endtask

  task automatic wait_frames(input int target);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (frames_a >= target) begin
        got = 1'b1;
        break;
      end
    end
    check_output("frame_end_timeout", got, 1'b1);
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [31:0] nibs,
                             input int rises, input int cs_low);
    if (idx < nib_hist.size()) begin
      check_output({tag, "_nibbles"}, nib_hist[idx], nibs);
      check_output({tag, "_rises"}, rise_hist[idx], rises);
      check_output({tag, "_cs_low"}, cs_hist[idx], cs_low);
    end else begin
      check_output({tag, "_frame_missing"}, idx, nib_hist.size());
    end
  endtask

  task automatic run_clkdiv1;
    logic [7:0] b_nibs;
    int b_rises, b_cs, b_done, b_bad, last;
    logic prev;
    b_nibs = '0; b_rises = 0; b_cs = 0; b_done = 0; b_bad = 0; last = 0; prev = 1'b0;
    @(negedge clk);
    b_if.in_valid = 1'b1;
    b_if.din      = 8'hA5;
    @(posedge clk);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 0) begin
        b_if.in_valid = 1'b0;
        b_if.din      = 8'h00;
      end
      if (b_if.cs_n === 1'b0) b_cs++;
      if (b_if.sclk === 1'b1 && prev === 1'b0) begin
        if (b_rises > 0 && (n - last) != 2) b_bad++;
        last   = n;
        b_nibs = {b_nibs[3:0], b_if.dout};
        b_rises++;
      end
      if (b_if.done === 1'b1) b_done++;
      prev = b_if.sclk;
    end
    check_output("div1_nibbles", b_nibs, 8'hA5);
    check_output("div1_rises", b_rises, 2);
    check_output("div1_cs_low", b_cs, 5);
    check_output("div1_done_pulses", b_done, 1);
    check_output("div1_sclk_period", b_bad, 0);
  endtask

  initial begin
    int start, idle_bad, done_before, frames_before;
    bit got;

    vecs[0] = '{din: 32'hDEADBEEF, exp_nibs: 32'hDEADBEEF, exp_rises: 8, exp_cs_low: 34, inject: 1'b0};
    vecs[1] = '{din: 32'h00000000, exp_nibs: 32'h00000000, exp_rises: 8, exp_cs_low: 34, inject: 1'b1};
    vecs[2] = '{din: 32'h3C96A50F, exp_nibs: 32'h3C96A50F, exp_rises: 8, exp_cs_low: 34, inject: 1'b0};

    a_if.in_valid = 1'b0;
    a_if.din      = '0;
    b_if.in_valid = 1'b0;
    b_if.din      = '0;

    #22;
    check_output("rst_cs_n", a_if.cs_n, 1'b1);
    check_output("rst_sclk", a_if.sclk, 1'b0);
    check_output("rst_dout", a_if.dout, 4'h0);
    check_output("rst_done", a_if.done, 1'b0);
    check_output("rst_busy", a_if.busy, 1'b0);
    check_output("rst_in_ready", a_if.in_ready, 1'b1);
    check_output("rst_b_cs_n", b_if.cs_n, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    idle_bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (a_if.cs_n !== 1'b1 || a_if.sclk !== 1'b0 || a_if.dout !== 4'h0 ||
          a_if.in_ready !== 1'b1 || a_if.done !== 1'b0 || a_if.busy !== 1'b0)
        idle_bad++;
    end
    check_output("idle_stable", idle_bad, 0);

    run_clkdiv1();

    for (int v = 0; v < 3; v++) begin
      start = frames_a;
      apply_stimulus(vecs[v].din);
      if (vecs[v].inject) begin
        repeat (10) @(negedge clk);
        a_if.in_valid = 1'b1;
        a_if.din      = 32'hFFFFFFFF;
        check_output("busy_in_ready", a_if.in_ready, 1'b0);
        check_output("busy_flag", a_if.busy, 1'b1);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        a_if.din      = '0;
      end
      wait_frames(start + 1);
      check_frame($sformatf("vec%0d", v), start, vecs[v].exp_nibs, vecs[v].exp_rises,
                  vecs[v].exp_cs_low);
      check_output("sclk_period", period_bad, 0);
      check_output("done_shape", done_bad, 0);
      if (vecs[v].inject) begin
        repeat (20) @(negedge clk);
        check_output("no_extra_frame", frames_a, start + 1);
        check_output("no_extra_cs", a_if.cs_n, 1'b1);
      end
    end

    // Back-to-back: in_valid held, second word taken in the done cycle
    start = frames_a;
    @(negedge clk);
    a_if.in_valid = 1'b1;
    a_if.din      = 32'h01234567;
    @(posedge clk);
    @(negedge clk);
    a_if.din = 32'h89ABCDEF;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (a_if.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check_output("b2b_ready_seen", got, 1'b1);
    check_output("b2b_done_with_ready", a_if.done, 1'b1);
    @(posedge clk);
    @(negedge clk);
    a_if.in_valid = 1'b0;
    a_if.din      = '0;
    check_output("b2b_second_started", a_if.cs_n, 1'b0);
    wait_frames(start + 2);
    check_frame("b2b_first", start, 32'h01234567, 8, 34);
    check_frame("b2b_second", start + 1, 32'h89ABCDEF, 8, 34);
    check_output("b2b_cs_gap", last_gap, 1);

    // Reset in the middle of a frame
    start = frames_a;
    apply_stimulus(32'hCAFEF00D);
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (acc_rises >= 3) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_output("midrst_reach_3_rises", got, 1'b1);
    done_before   = done_total;
    frames_before = frames_a;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_cs_n", a_if.cs_n, 1'b1);
    check_output("midrst_sclk", a_if.sclk, 1'b0);
    check_output("midrst_dout", a_if.dout, 4'h0);
    check_output("midrst_busy", a_if.busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_output("midrst_no_done", done_total, done_before);
    check_output("midrst_idle_ready", a_if.in_ready, 1'b1);
    start = frames_a;
    check_output("midrst_no_frame", start, frames_before);
    apply_stimulus(32'h12345678);
    wait_frames(start + 1);
    check_frame("post_rst", start, 32'h12345678, 8, 34);
    check_output("post_rst_period", period_bad, 0);
    check_output("post_rst_done_shape", done_bad, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
